// File: rtl/risc_word_loader.sv
// risc_word_loader: byte-to-word receive path for the RISC tile.
// Packs little-endian bytes from a valid/ready byte bus into 32-bit words and
// writes each word to RAM with a one-cycle strobe at an auto-incrementing,
// wrapping address. Used to bulk-load program memory before CPU release.
// Optional feature macro: RISC_LOADER_CHECKSUM_EN (running sum of written words).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; byte_ready low
// COLLECT | accepting bytes into lanes 0..3
// WRITE   | one-cycle RAM write of the assembled word
// DONE    | one-cycle done pulse, then back to IDLE
module risc_word_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  word_len,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              word_we,
  output logic [ADDR_W-1:0] word_addr,
  output logic [31:0]       word_data,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  word_count,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic [1:0]        r_lane;
  logic [23:0]       r_shift;
  logic [ADDR_W-1:0] r_word_addr;
  logic [31:0]       r_word_data;
  logic [LEN_W-1:0]  r_word_count;

  logic              w_start_ok;
  logic              w_accept;
  logic              w_last_byte;
  logic [ADDR_W-1:0] w_addr_inc;

  assign w_start_ok  = (r_state == S_IDLE) && start && !abort;
  assign w_accept    = (r_state == S_COLLECT) && byte_valid;
  assign w_last_byte = w_accept && (r_lane == 2'd3);
  // Explicit wrap so non-power-of-two DEPTH still wraps at DEPTH-1.
  assign w_addr_inc  = (r_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_addr + ADDR_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (start) w_next = (word_len == '0) ? S_DONE : S_COLLECT;
        S_COLLECT: if (w_last_byte) w_next = S_WRITE;
        S_WRITE:   w_next = (r_remaining == LEN_W'(1)) ? S_DONE : S_COLLECT;
        S_DONE:    w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Status and handshake outputs decoded from the current state.
  always_comb begin
    byte_ready = (r_state == S_COLLECT);
    word_we    = (r_state == S_WRITE);
    busy       = (r_state == S_COLLECT) || (r_state == S_WRITE);
    done       = (r_state == S_DONE);
  end

  // Burst bookkeeping and byte packing; a write already in flight completes even under abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_remaining  <= '0;
      r_lane       <= '0;
      r_shift      <= '0;
      r_word_addr  <= '0;
      r_word_data  <= '0;
      r_word_count <= '0;
    end else begin
      if (r_state == S_WRITE) begin
        r_addr       <= w_addr_inc;
        r_remaining  <= r_remaining - LEN_W'(1);
        r_word_count <= r_word_count + LEN_W'(1);
      end
      if (abort) begin
        r_lane  <= '0;
        r_shift <= '0;
      end else if (w_start_ok) begin
        r_addr       <= start_addr;
        r_remaining  <= word_len;
        r_word_count <= '0;
        r_lane       <= '0;
        r_shift      <= '0;
      end else if (w_accept) begin
        case (r_lane)
          2'd0: r_shift[7:0]   <= byte_data;
          2'd1: r_shift[15:8]  <= byte_data;
          2'd2: r_shift[23:16] <= byte_data;
          default: begin
            r_word_addr <= r_addr;
            r_word_data <= {byte_data, r_shift};
          end
        endcase
        r_lane <= r_lane + 2'd1;
      end
    end
  end

  assign word_addr  = r_word_addr;
  assign word_data  = r_word_data;
  assign word_count = r_word_count;

`ifdef RISC_LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Running sum of words written this burst; updated on the write cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_checksum <= '0;
    else if (w_start_ok)         r_checksum <= '0;
    else if (r_state == S_WRITE) r_checksum <= r_checksum + r_word_data;
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

endmodule
